// File: rtl/axis_lrelu_frame_tx_pkg.sv
// Shared constants for the LReLU frame transmitter and the LReLU engine:
// FSM state encoding, config beat counts and tuser bit positions.
package axis_lrelu_frame_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 2048;
  localparam int DEFAULT_TUSER_WIDTH = 11;
  localparam int DEFAULT_BEATS_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CFG  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int CONFIG_BEATS_3X3_1 = 20;
  localparam int CONFIG_BEATS_1X1_1 = 8;

  // tuser bit positions understood by the LReLU engine
  localparam int I_IS_NOT_MAX = 0;
  localparam int I_IS_MAX     = 1;
  localparam int I_IS_LRELU   = 2;
  localparam int I_IS_3X3     = 3;

endpackage

// File: rtl/axis_lrelu_frame_tx_if.sv
// Bus bundle of the frame transmitter: frame command, config stream,
// conv data stream and the AXIS master towards the LReLU engine.
interface axis_lrelu_frame_tx_if #(
  parameter int DATA_WIDTH  = axis_lrelu_frame_tx_pkg::DEFAULT_DATA_WIDTH,
  parameter int TUSER_WIDTH = axis_lrelu_frame_tx_pkg::DEFAULT_TUSER_WIDTH,
  parameter int BEATS_WIDTH = axis_lrelu_frame_tx_pkg::DEFAULT_BEATS_WIDTH
);
  import axis_lrelu_frame_tx_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_is_3x3;
  logic [BEATS_WIDTH-1:0] cmd_beats_1;

  logic                   s_cfg_tvalid;
  logic                   s_cfg_tready;
  logic [DATA_WIDTH-1:0]  s_cfg_tdata;

  logic                   s_dat_tvalid;
  logic                   s_dat_tready;
  logic [DATA_WIDTH-1:0]  s_dat_tdata;
  logic [TUSER_WIDTH-1:0] s_dat_tuser;

  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [DATA_WIDTH-1:0]  m_axis_tdata;
  logic [TUSER_WIDTH-1:0] m_axis_tuser;
  logic                   m_axis_tlast;

  logic                   frame_done;

  // transmitter side
  modport master (
    input  cmd_valid, cmd_is_3x3, cmd_beats_1,
    output cmd_ready,
    input  s_cfg_tvalid, s_cfg_tdata,
    output s_cfg_tready,
    input  s_dat_tvalid, s_dat_tdata, s_dat_tuser,
    output s_dat_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready,
    output frame_done
  );

  // environment side (command issuer, sources and LReLU engine)
  modport slave (
    output cmd_valid, cmd_is_3x3, cmd_beats_1,
    input  cmd_ready,
    output s_cfg_tvalid, s_cfg_tdata,
    input  s_cfg_tready,
    output s_dat_tvalid, s_dat_tdata, s_dat_tuser,
    input  s_dat_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
    output m_axis_tready,
    input  frame_done
  );

endinterface

// File: rtl/axis_lrelu_frame_tx_out_reg.sv
// Single-stage AXIS pipeline register carrying data, tuser and tlast.
// Accepts a new beat whenever it is empty or being drained this cycle,
// so it sustains one beat per clock under continuous ready.
module axis_out_reg #(
  parameter int DATA_WIDTH  = 2048,
  parameter int TUSER_WIDTH = 11
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [TUSER_WIDTH-1:0] in_user,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [TUSER_WIDTH-1:0] out_user,
  output logic                   out_last
);

  assign in_ready = !out_valid || out_ready;

  // load a new beat or empty out; everything holds while stalled
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_user <= in_user;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: rtl/axis_lrelu_frame_tx.sv
// Frame transmitter feeding the LReLU engine: per command, forwards the
// config words (21 for 3x3, 9 for 1x1) followed by the conv data beats of
// the frame, marking the final data beat with tlast.
module axis_lrelu_frame_tx #(
  parameter int DATA_WIDTH         = axis_lrelu_frame_tx_pkg::DEFAULT_DATA_WIDTH,
  parameter int TUSER_WIDTH        = axis_lrelu_frame_tx_pkg::DEFAULT_TUSER_WIDTH,
  parameter int I_IS_3X3           = axis_lrelu_frame_tx_pkg::I_IS_3X3,
  parameter int CONFIG_BEATS_3X3_1 = axis_lrelu_frame_tx_pkg::CONFIG_BEATS_3X3_1,
  parameter int CONFIG_BEATS_1X1_1 = axis_lrelu_frame_tx_pkg::CONFIG_BEATS_1X1_1,
  parameter int BEATS_WIDTH        = axis_lrelu_frame_tx_pkg::DEFAULT_BEATS_WIDTH
) (
  input logic                   aclk,
  input logic                   areset,
  axis_lrelu_frame_tx_if.master bus
);
  import axis_lrelu_frame_tx_pkg::*;

  localparam int CFG_MAX = (CONFIG_BEATS_3X3_1 > CONFIG_BEATS_1X1_1) ?
                           CONFIG_BEATS_3X3_1 : CONFIG_BEATS_1X1_1;
  localparam int CFG_W   = $clog2(CFG_MAX + 1);

  logic [1:0]             state;
  logic                   is_3x3_q;
  logic [CFG_W-1:0]       cfg_count;
  logic [BEATS_WIDTH-1:0] dat_count;

  logic                   load_en;
  logic                   src_valid;
  logic                   cfg_take;
  logic                   dat_take;
  logic [DATA_WIDTH-1:0]  beat_data;
  logic [TUSER_WIDTH-1:0] beat_user;
  logic                   beat_last;

  assign bus.cmd_ready    = (state == ST_IDLE);
  assign bus.s_cfg_tready = (state == ST_CFG)  && load_en;
  assign bus.s_dat_tready = (state == ST_DATA) && load_en;
  assign cfg_take         = (state == ST_CFG)  && bus.s_cfg_tvalid && load_en;
  assign dat_take         = (state == ST_DATA) && bus.s_dat_tvalid && load_en;
  assign bus.frame_done   = bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;

  // select the active source and build its sideband; the kernel type bit
  // always reflects the command, whatever the conv core put there
  always_comb begin
    src_valid = 1'b0;
    beat_data = bus.s_cfg_tdata;
    beat_user = '0;
    beat_last = 1'b0;
    case (state)
      ST_CFG: begin
        src_valid           = bus.s_cfg_tvalid;
        beat_user[I_IS_3X3] = is_3x3_q;
      end
      ST_DATA: begin
        src_valid           = bus.s_dat_tvalid;
        beat_data           = bus.s_dat_tdata;
        beat_user           = bus.s_dat_tuser;
        beat_user[I_IS_3X3] = is_3x3_q;
        beat_last           = (dat_count == '0);
      end
      default: ;
    endcase
  end

  // frame sequencing: counters load only in IDLE and count down to the exit beat
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      is_3x3_q  <= 1'b0;
      cfg_count <= '0;
      dat_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            is_3x3_q  <= bus.cmd_is_3x3;
            cfg_count <= bus.cmd_is_3x3 ? CFG_W'(CONFIG_BEATS_3X3_1)
                                        : CFG_W'(CONFIG_BEATS_1X1_1);
            dat_count <= bus.cmd_beats_1;
            state     <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (cfg_take) begin
            if (cfg_count == '0) state <= ST_DATA;
            else                 cfg_count <= cfg_count - 1'b1;
          end
        end
        ST_DATA: begin
          if (dat_take) begin
            if (dat_count == '0) state <= ST_IDLE;
            else                 dat_count <= dat_count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH)
  ) u_out_reg (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (src_valid),
    .in_ready  (load_en),
    .in_data   (beat_data),
    .in_user   (beat_user),
    .in_last   (beat_last),
    .out_valid (bus.m_axis_tvalid),
    .out_ready (bus.m_axis_tready),
    .out_data  (bus.m_axis_tdata),
    .out_user  (bus.m_axis_tuser),
    .out_last  (bus.m_axis_tlast)
  );

endmodule

// File: tb/tb_axis_lrelu_frame_tx.sv
// Bench for the LReLU frame transmitter: queue-fed sources, a scoreboard of
// expected output beats built from each frame command, and directed steps
// covering backpressure, queued commands, mid-frame reset and source stalls.
module tb_axis_lrelu_frame_tx;
  import axis_lrelu_frame_tx_pkg::*;

  localparam int DW = 2048;
  localparam int UW = 11;
  localparam int BW = 16;
  localparam int IDX_3X3 = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic          is_3x3;
    logic [BW-1:0] beats_1;
  } cmd_t;

  logic aclk = 1'b0;
  logic areset;

  axis_lrelu_frame_tx_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .BEATS_WIDTH(BW)) bus ();

  axis_lrelu_frame_tx #(
    .DATA_WIDTH         (DW),
    .TUSER_WIDTH        (UW),
    .I_IS_3X3           (3),
    .CONFIG_BEATS_3X3_1 (20),
    .CONFIG_BEATS_1X1_1 (8),
    .BEATS_WIDTH        (BW)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  beat_t         exp_q[$];
  cmd_t          cmd_q[$];
  logic [DW-1:0] cfg_q[$];
  beat_t         dat_q[$];
  int            cmd_acc_cyc[$];
  int            dat_last_cyc[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   done_count = 0;
  int   hold_checks = 0;
  int   bubbles = 0;
  int   dat_hold = 0;
  bit   mon_en = 1'b1;
  logic cmd_hs, cfg_hs, dat_hs;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_num(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // queue one frame: command, source words and the expected output beats
  task automatic apply_stimulus(input logic is3, input int beats_1, input int fid);
    cmd_t  c;
    beat_t e;
    beat_t d;
    logic [DW-1:0] w;
    int n_cfg;
    c.is_3x3  = is3;
    c.beats_1 = BW'(beats_1);
    cmd_q.push_back(c);
    n_cfg = is3 ? 21 : 9;
    for (int i = 0; i < n_cfg; i++) begin
      w = {64{fid[7:0], 8'hCF, i[15:0]}};
      cfg_q.push_back(w);
      e.data = w;
      e.user = '0;
      e.user[IDX_3X3] = is3;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i <= beats_1; i++) begin
      d.data = {64{fid[7:0], 8'hDA, i[15:0]}};
      d.user = UW'($urandom_range(0, 2047));
      d.last = (i == beats_1);
      dat_q.push_back(d);
      e.data = d.data;
      e.user = d.user;
      e.user[IDX_3X3] = is3;
      e.last = d.last;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_out(input int target, input int budget);
    for (int i = 0; i < budget && out_count < target; i++) begin
      @(posedge aclk); #1;
    end
    if (out_count < target) check_num("wait_out_timeout", out_count, target);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || cmd_q.size() != 0); i++) begin
      @(posedge aclk); #1;
    end
    check_num("drain_left", exp_q.size(), 0);
    repeat (2) begin
      @(posedge aclk); #1;
    end
  endtask

  // cycle counter used to time command and data acceptances
  always @(posedge aclk) cyc <= cyc + 1;

  // sample handshakes and check output beats against the scoreboard
  always @(negedge aclk) begin
    beat_t e;
    cmd_hs <= bus.cmd_valid && bus.cmd_ready;
    cfg_hs <= bus.s_cfg_tvalid && bus.s_cfg_tready;
    dat_hs <= bus.s_dat_tvalid && bus.s_dat_tready;
    if (bus.cmd_valid && bus.cmd_ready) cmd_acc_cyc.push_back(cyc);
    if (bus.s_dat_tvalid && bus.s_dat_tready && dat_q.size() > 0 && dat_q[0].last)
      dat_last_cyc.push_back(cyc);
    if (mon_en) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_num("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("tdata", bus.m_axis_tdata, e.data);
          check_num("tuser", int'(bus.m_axis_tuser), int'(e.user));
          check_bit("tlast", bus.m_axis_tlast, e.last);
          check_bit("frame_done", bus.frame_done, e.last);
        end
        out_count++;
      end else begin
        check_bit("frame_done_idle", bus.frame_done, 1'b0);
        if (bus.m_axis_tvalid && exp_q.size() > 0) begin
          check_output("hold_tdata", bus.m_axis_tdata, exp_q[0].data);
          check_num("hold_tuser", int'(bus.m_axis_tuser), int'(exp_q[0].user));
          check_bit("hold_tlast", bus.m_axis_tlast, exp_q[0].last);
          hold_checks++;
        end
        if (!bus.m_axis_tvalid && exp_q.size() > 0) bubbles++;
      end
      if (bus.frame_done) done_count++;
    end
  end

  // source models: retire a handshaken word, then present the next one
  always @(posedge aclk) begin
    #1;
    if (cmd_hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
    if (cfg_hs && cfg_q.size() > 0) void'(cfg_q.pop_front());
    if (dat_hs && dat_q.size() > 0) void'(dat_q.pop_front());
    bus.cmd_valid = (cmd_q.size() > 0);
    if (cmd_q.size() > 0) begin
      bus.cmd_is_3x3  = cmd_q[0].is_3x3;
      bus.cmd_beats_1 = cmd_q[0].beats_1;
    end
    bus.s_cfg_tvalid = (cfg_q.size() > 0);
    if (cfg_q.size() > 0) bus.s_cfg_tdata = cfg_q[0];
    if (dat_hold > 0) begin
      bus.s_dat_tvalid = 1'b0;
      dat_hold--;
    end else begin
      bus.s_dat_tvalid = (dat_q.size() > 0);
      if (dat_q.size() > 0) begin
        bus.s_dat_tdata = dat_q[0].data;
        bus.s_dat_tuser = dat_q[0].user;
      end
    end
  end

  initial begin
    int base_out, base_done, base_hold, cb, db;
    areset            = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_is_3x3    = 1'b0;
    bus.cmd_beats_1   = '0;
    bus.s_cfg_tvalid  = 1'b0;
    bus.s_cfg_tdata   = '0;
    bus.s_dat_tvalid  = 1'b0;
    bus.s_dat_tdata   = '0;
    bus.s_dat_tuser   = '0;

    // reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_bit("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check_bit("rst_tlast", bus.m_axis_tlast, 1'b0);
    check_output("rst_tdata", bus.m_axis_tdata, '0);
    check_num("rst_tuser", int'(bus.m_axis_tuser), 0);
    check_bit("rst_frame_done", bus.frame_done, 1'b0);
    check_bit("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_bit("rst_cfg_tready", bus.s_cfg_tready, 1'b0);
    check_bit("rst_dat_tready", bus.s_dat_tready, 1'b0);
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (2) begin
      @(posedge aclk); #1;
    end

    // 3x3 frame with four data beats
    $display("[TB] 3x3 frame, 4 data beats");
    base_out = out_count; base_done = done_count;
    apply_stimulus(1'b1, 3, 1);
    wait_drain(300);
    check_num("f1_beats", out_count - base_out, 25);
    check_num("f1_done", done_count - base_done, 1);

    // 1x1 frame with a single data beat
    $display("[TB] 1x1 frame, 1 data beat");
    base_out = out_count; base_done = done_count;
    apply_stimulus(1'b0, 0, 2);
    wait_drain(300);
    check_num("f2_beats", out_count - base_out, 10);
    check_num("f2_done", done_count - base_done, 1);

    // output backpressure during config beats
    $display("[TB] backpressure in CFG");
    base_out = out_count; base_done = done_count; base_hold = hold_checks;
    apply_stimulus(1'b1, 1, 3);
    wait_out(base_out + 3, 100);
    bus.m_axis_tready = 1'b0;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    bus.m_axis_tready = 1'b1;
    wait_drain(300);
    check_num("f3_hold_cycles", hold_checks - base_hold, 2);
    check_num("f3_beats", out_count - base_out, 23);
    check_num("f3_done", done_count - base_done, 1);

    // two queued commands back to back
    $display("[TB] queued commands");
    base_done = done_count;
    cb = cmd_acc_cyc.size(); db = dat_last_cyc.size();
    apply_stimulus(1'b1, 1, 4);
    apply_stimulus(1'b0, 0, 5);
    wait_drain(400);
    check_num("f4_done", done_count - base_done, 2);
    check_num("f4_cmds_accepted", cmd_acc_cyc.size() - cb, 2);
    if (cmd_acc_cyc.size() >= cb + 2 && dat_last_cyc.size() > db)
      check_num("f4_cmd_gap", cmd_acc_cyc[cb + 1] - dat_last_cyc[db], 1);

    // reset in the middle of the config beats
    $display("[TB] mid-frame reset");
    base_out = out_count;
    apply_stimulus(1'b1, 5, 6);
    wait_out(base_out + 5, 100);
    mon_en = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete(); cfg_q.delete(); dat_q.delete(); cmd_q.delete();
    dat_hold = 0;
    @(negedge aclk);
    check_bit("mid_rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check_bit("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_bit("mid_rst_frame_done", bus.frame_done, 1'b0);
    mon_en = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
    end
    base_out = out_count; base_done = done_count;
    apply_stimulus(1'b0, 2, 7);
    wait_drain(300);
    check_num("f7_beats", out_count - base_out, 12);
    check_num("f7_done", done_count - base_done, 1);

    // conv data source stalls mid-frame
    $display("[TB] data source stall");
    base_out = out_count; base_done = done_count;
    apply_stimulus(1'b0, 5, 8);
    wait_out(base_out + 10, 100);
    dat_hold = 3;
    bubbles = 0;
    wait_drain(300);
    check_num("f8_bubbles", bubbles, 3);
    check_num("f8_beats", out_count - base_out, 15);
    check_num("f8_done", done_count - base_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
